// File: rtl/pipelined_barrel_shifter_if.sv
// Op/result stream bundle for the pipelined barrel shifter.
// The master drives ops and consumes results; the slave is the shifter.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_amt;
    logic               in_dir;
    logic [1:0]         in_op;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_data, in_amt, in_dir, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_dir, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Log-stage barrel shifter/rotator with optional per-stage registers
// and a global-stall valid/ready pipeline carrying a side tag.
module pipelined_barrel_shifter #(
    parameter int WIDTH    = 8,
    parameter int PIPELINE = 1,
    parameter int TAG_W    = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int NSTG    = (PIPELINE != 0) ? SHAMT_W : 1;

    typedef struct packed {
        logic               vld;
        logic [TAG_W-1:0]   tag;
        logic [SHAMT_W-1:0] amt;
        logic               dir;
        logic [1:0]         op;
        logic               sgn;
        logic [WIDTH-1:0]   data;
    } op_t;

    op_t  ent;
    op_t  d [NSTG];
    op_t  q [NSTG];
    logic adv;

    assign adv          = !q[NSTG-1].vld | bus.out_ready;
    assign bus.in_ready = adv & rst_n;

    // in_ready equals adv whenever state can change, so in_valid alone marks the entry
    always_comb begin
        ent      = '0;
        ent.vld  = bus.in_valid;
        ent.tag  = bus.in_tag;
        ent.amt  = bus.in_amt;
        ent.dir  = bus.in_dir;
        ent.op   = bus.in_op;
        ent.sgn  = bus.in_data[WIDTH-1];
        ent.data = bus.in_data;
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stg
        localparam int S = 1 << k;
        op_t s_in;
        op_t s_out;

        if (k == 0) begin : g_src
            assign s_in = ent;
        end else if (PIPELINE != 0) begin : g_src
            assign s_in = q[k-1];
        end else begin : g_src
            assign s_in = g_stg[k-1].s_out;
        end

        always_comb begin
            s_out = s_in;
            if (s_in.amt[k]) begin
                unique case (s_in.op)
                    2'b01: s_out.data = s_in.dir
                        ? {{S{1'b0}}, s_in.data[WIDTH-1:S]}
                        : {s_in.data[WIDTH-1-S:0], {S{1'b0}}};
                    2'b10: s_out.data = s_in.dir
                        ? {{S{s_in.sgn}}, s_in.data[WIDTH-1:S]}
                        : {s_in.data[WIDTH-1-S:0], {S{1'b0}}};
                    default: s_out.data = s_in.dir
                        ? {s_in.data[S-1:0], s_in.data[WIDTH-1:S]}
                        : {s_in.data[WIDTH-1-S:0], s_in.data[WIDTH-1:WIDTH-S]};
                endcase
            end
        end
    end

    if (PIPELINE != 0) begin : g_pipe
        for (genvar k = 0; k < NSTG; k++) begin : g_d
            assign d[k] = g_stg[k].s_out;
        end
    end else begin : g_flat
        assign d[0] = g_stg[SHAMT_W-1].s_out;
    end

    // Global stall: all stages move together, bubbles included
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTG; i++) q[i] <= '0;
        end else if (adv) begin
            for (int i = 0; i < NSTG; i++) q[i] <= d[i];
        end
    end

    assign bus.out_valid = q[NSTG-1].vld;
    assign bus.out_data  = q[NSTG-1].data;
    assign bus.out_tag   = q[NSTG-1].tag;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for the pipelined barrel shifter: 8-bit pipelined
// instance plus a 32-bit single-register instance.
module tb_pipelined_barrel_shifter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_barrel_shifter_if #(.WIDTH(8), .TAG_W(4)) a ();
    pipelined_barrel_shifter_if #(.WIDTH(32), .TAG_W(4)) b ();

    pipelined_barrel_shifter #(.WIDTH(8), .PIPELINE(1), .TAG_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(a.slave)
    );
    pipelined_barrel_shifter #(.WIDTH(32), .PIPELINE(0), .TAG_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(b.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] qa_d[$];
    logic [3:0]  qa_t[$];
    logic [31:0] qb_d[$];
    logic [3:0]  qb_t[$];
    int got = 0, first_c = 0, last_c = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit-at-a-time reference: one position per iteration
    function automatic logic [31:0] model(input logic [31:0] d, input int amt,
                                          input bit dir, input logic [1:0] op,
                                          input int w);
        logic [31:0] r;
        logic [31:0] mask;
        logic sgn;
        logic fill;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        r = d & mask;
        sgn = r[w-1];
        for (int i = 0; i < amt; i++) begin
            if (dir) begin
                fill = (op == 2'b01) ? 1'b0 : (op == 2'b10) ? sgn : r[0];
                r = r >> 1;
                r[w-1] = fill;
            end else begin
                fill = (op == 2'b01 || op == 2'b10) ? 1'b0 : r[w-1];
                r = r << 1;
                r[0] = fill;
            end
            r = r & mask;
        end
        return r;
    endfunction

    task automatic drive_a(input logic [7:0] d, input logic [2:0] amt,
                           input bit dir, input logic [1:0] op,
                           input logic [3:0] tag, input bit v);
        a.in_data = d; a.in_amt = amt; a.in_dir = dir;
        a.in_op = op; a.in_tag = tag; a.in_valid = v;
    endtask

    task automatic drive_b(input logic [31:0] d, input logic [4:0] amt,
                           input bit dir, input logic [1:0] op,
                           input logic [3:0] tag, input bit v);
        b.in_data = d; b.in_amt = amt; b.in_dir = dir;
        b.in_op = op; b.in_tag = tag; b.in_valid = v;
    endtask

    task automatic tick_a(output bit acc);
        #2;
        acc = a.in_valid && a.in_ready;
        if (a.out_valid && a.out_ready) begin
            check("a_expected_pending", 32'(qa_d.size() != 0), 32'd1);
            if (qa_d.size() != 0) begin
                check("a_data", 32'(a.out_data), qa_d.pop_front());
                check("a_tag", 32'(a.out_tag), 32'(qa_t.pop_front()));
                if (got == 0) first_c = cyc;
                last_c = cyc;
                got++;
            end
        end
        if (acc) begin
            qa_d.push_back(model(32'(a.in_data), int'(a.in_amt), a.in_dir, a.in_op, 8));
            qa_t.push_back(a.in_tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic tick_b(output bit acc);
        #2;
        acc = b.in_valid && b.in_ready;
        if (b.out_valid && b.out_ready) begin
            check("b_expected_pending", 32'(qb_d.size() != 0), 32'd1);
            if (qb_d.size() != 0) begin
                check("b_data", b.out_data, qb_d.pop_front());
                check("b_tag", 32'(b.out_tag), 32'(qb_t.pop_front()));
                got++;
            end
        end
        if (acc) begin
            qb_d.push_back(model(b.in_data, int'(b.in_amt), b.in_dir, b.in_op, 32));
            qb_t.push_back(b.in_tag);
        end
        @(posedge clk); #1;
    endtask

    // Latency counts edges from the accepting edge (inclusive) to out_valid
    task automatic single_a(input string name, input logic [7:0] d,
                            input logic [2:0] amt, input bit dir,
                            input logic [1:0] op, input logic [3:0] tag,
                            input logic [7:0] exp);
        int n;
        drive_a(d, amt, dir, op, tag, 1'b1);
        #1;
        check({name, "_rdy"}, 32'(a.in_ready), 32'd1);
        @(posedge clk); #1;
        a.in_valid = 1'b0;
        n = 1;
        while (!a.out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_lat"}, 32'(n), 32'd3);
        check({name, "_data"}, 32'(a.out_data), 32'(exp));
        check({name, "_tag"}, 32'(a.out_tag), 32'(tag));
        @(posedge clk); #1;
    endtask

    task automatic single_b(input string name, input logic [31:0] d,
                            input logic [4:0] amt, input bit dir,
                            input logic [1:0] op, input logic [31:0] exp);
        int n;
        drive_b(d, amt, dir, op, 4'h5, 1'b1);
        #1;
        check({name, "_rdy"}, 32'(b.in_ready), 32'd1);
        @(posedge clk); #1;
        b.in_valid = 1'b0;
        n = 1;
        while (!b.out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_lat"}, 32'(n), 32'd1);
        check({name, "_data"}, b.out_data, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        bit acc;
        int j;
        int stall_n;
        logic [7:0] held_d;
        logic [3:0] held_t;

        drive_a(8'h0, 3'd0, 1'b0, 2'b00, 4'h0, 1'b0);
        drive_b(32'h0, 5'd0, 1'b0, 2'b00, 4'h0, 1'b0);
        a.out_ready = 1'b1;
        b.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_vld", 32'(a.out_valid), 32'd0);
        check("rst_a_data", 32'(a.out_data), 32'd0);
        check("rst_a_tag", 32'(a.out_tag), 32'd0);
        check("rst_a_rdy", 32'(a.in_ready), 32'd0);
        check("rst_b_vld", 32'(b.out_valid), 32'd0);
        check("rst_b_data", b.out_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        single_a("ror3", 8'hB1, 3'd3, 1'b1, 2'b00, 4'h1, 8'h36);
        single_a("rol1", 8'hB1, 3'd1, 1'b0, 2'b00, 4'h2, 8'h63);
        single_a("lsr2", 8'hB1, 3'd2, 1'b1, 2'b01, 4'h3, 8'h2C);
        single_a("asr2", 8'hB1, 3'd2, 1'b1, 2'b10, 4'h4, 8'hEC);
        single_a("lsl4", 8'hB1, 3'd4, 1'b0, 2'b01, 4'h5, 8'h10);
        single_a("asl4", 8'hB1, 3'd4, 1'b0, 2'b10, 4'h6, 8'h10);
        single_a("rsv_rol1", 8'hB1, 3'd1, 1'b0, 2'b11, 4'h7, 8'h63);
        single_a("asr0", 8'hB1, 3'd0, 1'b1, 2'b10, 4'h8, 8'hB1);
        single_a("asr7_pos", 8'h7F, 3'd7, 1'b1, 2'b10, 4'h9, 8'h00);

        got = 0;
        j = 0;
        for (int c = 0; c < 60 && (j < 16 || qa_d.size() != 0); c++) begin
            if (j < 16)
                drive_a(8'h5A ^ 8'(j * 37), 3'(j), j[0], 2'(j / 2), 4'(j), 1'b1);
            else
                a.in_valid = 1'b0;
            tick_a(acc);
            if (acc) j++;
        end
        check("stream_count", 32'(got), 32'd16);
        check("stream_span", 32'(last_c - first_c), 32'd15);

        got = 0;
        j = 0;
        stall_n = 0;
        held_d = '0;
        held_t = '0;
        for (int c = 0; c < 80 && (j < 12 || qa_d.size() != 0); c++) begin
            a.out_ready = !(c >= 5 && c < 10);
            if (j < 12)
                drive_a(8'hC3 + 8'(j * 11), 3'(j + 1), j[1], 2'(j), 4'(j), 1'b1);
            else
                a.in_valid = 1'b0;
            #1;
            if (!a.out_ready) begin
                check("bp_in_ready", 32'(a.in_ready), 32'd0);
                check("bp_out_valid", 32'(a.out_valid), 32'd1);
                if (stall_n > 0) begin
                    check("bp_data_stable", 32'(a.out_data), 32'(held_d));
                    check("bp_tag_stable", 32'(a.out_tag), 32'(held_t));
                end
                held_d = a.out_data;
                held_t = a.out_tag;
                stall_n++;
            end
            tick_a(acc);
            if (acc) j++;
        end
        a.out_ready = 1'b1;
        check("bp_count", 32'(got), 32'd12);
        check("bp_stall_cycles", 32'(stall_n), 32'd5);

        for (int k = 0; k < 3; k++) begin
            drive_a(8'h11 * 8'(k + 1), 3'd1, 1'b0, 2'b00, 4'(k + 1), 1'b1);
            tick_a(acc);
        end
        rst_n = 1'b0;
        a.in_valid = 1'b0;
        #1;
        check("rstmid_rdy", 32'(a.in_ready), 32'd0);
        @(posedge clk); #1;
        check("rstmid_vld", 32'(a.out_valid), 32'd0);
        check("rstmid_data", 32'(a.out_data), 32'd0);
        check("rstmid_tag", 32'(a.out_tag), 32'd0);
        qa_d.delete();
        qa_t.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        single_a("post_rst", 8'hB1, 3'd3, 1'b1, 2'b00, 4'hA, 8'h36);

        single_b("w32_rot0", 32'h8000_0001, 5'd0, 1'b1, 2'b00, 32'h8000_0001);
        single_b("w32_ror31", 32'h8000_0001, 5'd31, 1'b1, 2'b00, 32'h0000_0003);
        single_b("w32_rol31", 32'h8000_0001, 5'd31, 1'b0, 2'b00, 32'hC000_0000);
        single_b("w32_lsr31", 32'h8000_0001, 5'd31, 1'b1, 2'b01, 32'h0000_0001);
        single_b("w32_asr31", 32'h8000_0001, 5'd31, 1'b1, 2'b10, 32'hFFFF_FFFF);
        single_b("w32_lsl31", 32'h8000_0001, 5'd31, 1'b0, 2'b01, 32'h8000_0000);
        single_b("w32_asr0", 32'h8000_0001, 5'd0, 1'b1, 2'b10, 32'h8000_0001);

        got = 0;
        j = 0;
        for (int c = 0; c < 80 && (j < 24 || qb_d.size() != 0); c++) begin
            if (j < 24)
                drive_b($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                        2'($urandom_range(0, 3)), 4'(j), 1'b1);
            else
                b.in_valid = 1'b0;
            tick_b(acc);
            if (acc) j++;
        end
        check("w32_rand_count", 32'(got), 32'd24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
